mdu_issue_ctrl: RTL and testbench

Pipeline-side initiator for the multi-cycle `mdu` start/busy/done handshake.
- Accepts a decoded M-extension instruction from the execute stage.
- Stalls the pipeline and pulses `start` to the MDU.
- Waits for `done`, selects the correct result half for funct3, and presents a single-cycle writeback.
- Sits between the ID/EX register and the EX/WB mux; the MDU is instantiated beside it.

---
 rtl/mdu_issue_ctrl_pkg.sv | 16 +
 rtl/mdu_result_sel.sv | 17 +
 rtl/mdu_issue_ctrl.sv | 117 +++++++++++
 tb/tb_mdu_issue_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_issue_ctrl_pkg.sv
// mdu_issue_ctrl_pkg: funct3 codes, issue FSM state encoding and the fuse-hit rule
package mdu_issue_ctrl_pkg;
    localparam logic [2:0] FUNCT3_MUL    = 3'b000;
    localparam logic [2:0] FUNCT3_MULH   = 3'b001;
    localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
    localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
    localparam logic [2:0] FUNCT3_DIV    = 3'b100;
    localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
    localparam logic [2:0] FUNCT3_REM    = 3'b110;
    localparam logic [2:0] FUNCT3_REMU   = 3'b111;
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESULT} mdu_state_e;
    // MUL only needs the low product half, which every mul-group op leaves identical
    function automatic logic fuse_hit(input logic [2:0] f, input logic [2:0] c);
        return (f == FUNCT3_MUL) ? !c[2] : !f[2] ? f == c : c[2] && f[0] == c[0];
    endfunction
endpackage

// File: rtl/mdu_result_sel.sv
// mdu_result_sel: picks the architectural result for funct3 from the mdu outputs
module mdu_result_sel
    import mdu_issue_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]        funct3,
    input  logic [2*XLEN-1:0] product,
    input  logic [XLEN-1:0]   quotient,
    input  logic [XLEN-1:0]   remainder,
    output logic [XLEN-1:0]   result
);
    always_comb
        result = (funct3 == FUNCT3_MUL) ? product[XLEN-1:0] :
                 !funct3[2]             ? product[2*XLEN-1:XLEN] :
                 !funct3[1]             ? quotient : remainder;
endmodule

// File: rtl/mdu_issue_ctrl.sv
// mdu_issue_ctrl: pipeline-side start/busy/done initiator for the mdu; MDU_FUSE_EN adds last-result reuse
module mdu_issue_ctrl
    import mdu_issue_ctrl_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    input  logic [2:0]        instr_funct3,
    input  logic [XLEN-1:0]   rs1_val,
    input  logic [XLEN-1:0]   rs2_val,
    input  logic [RA_W-1:0]   rd_addr,
    input  logic              flush,
    output logic              mdu_start,
    output logic [2:0]        mdu_funct3,
    output logic [XLEN-1:0]   mdu_a,
    output logic [XLEN-1:0]   mdu_b,
    input  logic              mdu_busy,
    input  logic              mdu_done,
    input  logic [2*XLEN-1:0] mdu_product,
    input  logic [XLEN-1:0]   mdu_quotient,
    input  logic [XLEN-1:0]   mdu_remainder,
    output logic              stall,
    output logic              wb_valid,
    output logic [RA_W-1:0]   wb_rd,
    output logic [XLEN-1:0]   wb_data
);
    mdu_state_e state;
    logic drop;
    logic accept;
    logic hit;
    logic [XLEN-1:0] live_res;
    logic [XLEN-1:0] fuse_res;

    assign accept    = state == S_IDLE && instr_valid && !flush;
    assign stall     = (state == S_IDLE) ? accept : state != S_RESULT;
    assign mdu_start = state == S_ISSUE && !mdu_busy && !flush;
    assign wb_valid  = state == S_RESULT && !flush;

    mdu_result_sel #(.XLEN(XLEN)) u_sel_live (
        .funct3(mdu_funct3), .product(mdu_product), .quotient(mdu_quotient),
        .remainder(mdu_remainder), .result(live_res)
    );

`ifdef MDU_FUSE_EN
    logic              c_valid;
    logic [2:0]        c_f;
    logic [XLEN-1:0]   c_a, c_b, c_quo, c_rem;
    logic [2*XLEN-1:0] c_prod;

    // Every completion refreshes the cache, even one whose writeback was squashed
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            c_valid <= 1'b0;
            c_f     <= '0;
            c_a     <= '0;
            c_b     <= '0;
            c_prod  <= '0;
            c_quo   <= '0;
            c_rem   <= '0;
        end else if (state == S_WAIT && mdu_done) begin
            c_valid <= 1'b1;
            c_f     <= mdu_funct3;
            c_a     <= mdu_a;
            c_b     <= mdu_b;
            c_prod  <= mdu_product;
            c_quo   <= mdu_quotient;
            c_rem   <= mdu_remainder;
        end

    assign hit = c_valid && rs1_val == c_a && rs2_val == c_b && fuse_hit(instr_funct3, c_f);

    mdu_result_sel #(.XLEN(XLEN)) u_sel_fuse (
        .funct3(instr_funct3), .product(c_prod), .quotient(c_quo),
        .remainder(c_rem), .result(fuse_res)
    );
`else
    assign hit      = 1'b0;
    assign fuse_res = '0;
`endif

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state      <= S_IDLE;
            drop       <= 1'b0;
            mdu_funct3 <= '0;
            mdu_a      <= '0;
            mdu_b      <= '0;
            wb_rd      <= '0;
            wb_data    <= '0;
        end else begin
            case (state)
                S_IDLE:
                    if (accept) begin
                        mdu_funct3 <= instr_funct3;
                        mdu_a      <= rs1_val;
                        mdu_b      <= rs2_val;
                        wb_rd      <= rd_addr;
                        drop       <= 1'b0;
                        state      <= hit ? S_RESULT : S_ISSUE;
                        if (hit) wb_data <= fuse_res;
                    end
                S_ISSUE:
                    if (flush) state <= S_IDLE;
                    else if (!mdu_busy) state <= S_WAIT;
                // The mdu cannot be aborted, so a flush only marks the result as dead
                S_WAIT: begin
                    drop <= mdu_done ? 1'b0 : drop | flush;
                    if (mdu_done) state <= (flush || drop) ? S_IDLE : S_RESULT;
                    if (mdu_done && !flush && !drop) wb_data <= live_res;
                end
                default: state <= S_IDLE;
            endcase
        end
endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// tb_mdu_issue_ctrl: randomized scoreboard bench with a behavioural mdu and RISC-V M reference
module tb_mdu_issue_ctrl;
    import mdu_issue_ctrl_pkg::*;

    logic        clk = 0, rst_n = 0;
    logic        instr_valid = 0, flush = 0;
    logic [2:0]  instr_funct3 = 0;
    logic [31:0] rs1_val = 0, rs2_val = 0;
    logic [4:0]  rd_addr = 0;
    logic        mdu_start, stall, wb_valid;
    logic [2:0]  mdu_funct3;
    logic [31:0] mdu_a, mdu_b, wb_data;
    logic [4:0]  wb_rd;
    logic        ext_busy = 0, mdl_busy = 0, mdu_done = 0;
    logic        mdu_busy;
    logic [63:0] mdu_product = 0;
    logic [31:0] mdu_quotient = 0, mdu_remainder = 0;

    assign mdu_busy = ext_busy | mdl_busy;

    mdu_issue_ctrl #(.XLEN(32), .RA_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_funct3(instr_funct3),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .rd_addr(rd_addr), .flush(flush),
        .mdu_start(mdu_start), .mdu_funct3(mdu_funct3), .mdu_a(mdu_a), .mdu_b(mdu_b),
        .mdu_busy(mdu_busy), .mdu_done(mdu_done), .mdu_product(mdu_product),
        .mdu_quotient(mdu_quotient), .mdu_remainder(mdu_remainder), .stall(stall),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];
    int n_cmp = 0, n_bad = 0;
    int next_lat = 1;
`ifdef MDU_FUSE_EN
    logic        cv = 0;
    logic [2:0]  cf = 0;
    logic [31:0] ca = 0, cb = 0;
    bit          orphan = 0;
`endif

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Architectural RISC-V M results computed straight from the ISA definition
    function automatic logic [31:0] ref_res(logic [2:0] f, logic [31:0] a, logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'({32'b0, a});
        longint ub = longint'({32'b0, b});
        logic [63:0] p;
        case (f)
            FUNCT3_MUL:    begin p = sa * sb; return p[31:0]; end
            FUNCT3_MULH:   begin p = sa * sb; return p[63:32]; end
            FUNCT3_MULHSU: begin p = sa * ub; return p[63:32]; end
            FUNCT3_MULHU:  begin p = ua * ub; return p[63:32]; end
            FUNCT3_DIV:    begin p = (b == 0) ? -64'sd1 : sa / sb; return p[31:0]; end
            FUNCT3_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            FUNCT3_REM:    begin p = (b == 0) ? sa : sa % sb; return p[31:0]; end
            default:       return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Behavioural mdu: samples start mid-cycle, raises done next_lat cycles later
    initial begin
        logic st;
        logic [2:0] mf, sf;
        logic [31:0] ma, mb, sa, sb;
        logic [63:0] ea, eb;
        int cnt;
        bit fire;
        cnt = 0;
        mf = 0; ma = 0; mb = 0;
        forever begin
            @(negedge clk);
            #3;
            st = mdu_start; sf = mdu_funct3; sa = mdu_a; sb = mdu_b;
            @(posedge clk);
            #1;
            fire = 0;
            if (mdu_done) begin
                mdu_done = 0;
                mdl_busy = 0;
            end else if (st) begin
                mf = sf; ma = sa; mb = sb;
                cnt = next_lat;
                mdl_busy = 1;
                fire = cnt == 0;
            end else if (mdl_busy) begin
                cnt--;
                fire = cnt == 0;
            end
            if (fire) begin
                ea = (mf == FUNCT3_MULH || mf == FUNCT3_MULHSU) ? {{32{ma[31]}}, ma} : {32'b0, ma};
                eb = (mf == FUNCT3_MULH) ? {{32{mb[31]}}, mb} : {32'b0, mb};
                if (!mf[2]) begin
                    mdu_product = ea * eb;
                    mdu_quotient = $urandom;
                    mdu_remainder = $urandom;
                end else begin
                    mdu_product = {$urandom, $urandom};
                    if (mb == 0) begin
                        mdu_quotient = '1; mdu_remainder = ma;
                    end else if (!mf[0] && ma == 32'h8000_0000 && mb == 32'hFFFF_FFFF) begin
                        mdu_quotient = ma; mdu_remainder = 0;
                    end else if (!mf[0]) begin
                        mdu_quotient = $signed(ma) / $signed(mb);
                        mdu_remainder = $signed(ma) % $signed(mb);
                    end else begin
                        mdu_quotient = ma / mb; mdu_remainder = ma % mb;
                    end
                end
                mdu_done = 1;
`ifdef MDU_FUSE_EN
                if (orphan) orphan = 0;
                else begin cv = 1; cf = mf; ca = ma; cb = mb; end
`endif
            end
        end
    end

    // Monitor: every writeback strobe must match the oldest outstanding expectation
    initial forever begin
        exp_t e;
        @(negedge clk);
        #2;
        if (rst_n && wb_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL spurious_wb: rd %0d data %h with nothing expected", wb_rd, wb_data);
            end else begin
                e = exp_q.pop_front();
                chk("wb_rd", 64'(wb_rd), 64'(e.rd));
                chk("wb_data", 64'(wb_data), 64'(e.data));
            end
        end
    end

    task automatic idle(int n);
        repeat (n) begin
            @(negedge clk);
            instr_valid = 0; flush = 0; ext_busy = 0;
        end
    endtask

    // Presents one op the way the pipeline would; k = cycles of foreign busy, fl = flush cycle
    task automatic run_op(logic [2:0] f, logic [31:0] a, logic [31:0] b, logic [4:0] rd,
                          int k, int fl, int lat);
        int c = 0, start_c = -1, done_c = -1, wb_c = -1, end_c = -1, fl_c = -1;
        bit killed = 0, hit = 0;
`ifdef MDU_FUSE_EN
        hit = fl != 0 && cv && a == ca && b == cb &&
              ((f == FUNCT3_MUL && cf inside {FUNCT3_MUL, FUNCT3_MULH, FUNCT3_MULHSU, FUNCT3_MULHU}) ||
               (f inside {FUNCT3_MULH, FUNCT3_MULHSU, FUNCT3_MULHU} && f == cf) ||
               (f inside {FUNCT3_DIV, FUNCT3_REM} && cf inside {FUNCT3_DIV, FUNCT3_REM}) ||
               (f inside {FUNCT3_DIVU, FUNCT3_REMU} && cf inside {FUNCT3_DIVU, FUNCT3_REMU}));
`endif
        next_lat = lat;
        exp_q.push_back('{rd, ref_res(f, a, b)});
        while (end_c < 0 && c < 80) begin
            @(negedge clk);
            instr_valid = !killed; instr_funct3 = f; rs1_val = a; rs2_val = b; rd_addr = rd;
            flush = c == fl;
            ext_busy = c < k;
            #1;
            if (flush) begin killed = 1; fl_c = c; end
            if (mdu_start && start_c < 0) start_c = c;
            if (mdu_done) done_c = c;
            if (wb_valid) wb_c = c;
            if (!stall) end_c = c;
            c++;
        end
        instr_valid = 0;
        if (killed && exp_q.size() > 0) void'(exp_q.pop_back());
        chk("op_finished", 64'(end_c >= 0), 64'd1);
        if (end_c >= 0) begin
            if (killed) begin
                if (hit) chk("kill_end_hit", 64'(end_c), 64'(fl_c));
                else if (start_c >= 0) chk("kill_end_after_done", 64'(end_c), 64'(done_c + 1));
                else chk("kill_end_nostart", 64'(end_c), 64'(fl_c == 0 ? 0 : fl_c + 1));
                chk("kill_no_wb", 64'(wb_c), 64'(-1));
            end else if (hit) begin
                chk("hit_no_start", 64'(start_c), 64'(-1));
                chk("hit_wb_cycle", 64'(wb_c), 64'd1);
                chk("hit_stall_drop", 64'(end_c), 64'd1);
            end else begin
                chk("start_latency", 64'(start_c), 64'(k > 1 ? k : 1));
                chk("wb_after_done", 64'(wb_c), 64'(done_c + 1));
                chk("stall_drop_wb", 64'(end_c), 64'(wb_c));
            end
        end
    endtask

    task automatic check_zero_outputs(string tag);
        chk({tag, "_ctl"}, 64'({mdu_start, wb_valid, stall, mdu_funct3, wb_rd}), 64'd0);
        chk({tag, "_a"}, 64'(mdu_a), 64'd0);
        chk({tag, "_b"}, 64'(mdu_b), 64'd0);
        chk({tag, "_wb_data"}, 64'(wb_data), 64'd0);
    endtask

    task automatic reset_mid_wait();
        int c = 0;
        next_lat = 8;
        @(negedge clk);
        instr_valid = 1; instr_funct3 = FUNCT3_MUL; rs1_val = 5; rs2_val = 5; rd_addr = 3;
        flush = 0; ext_busy = 0;
        #1;
        while (!mdu_start && c < 10) begin
            @(negedge clk);
            #1;
            c++;
        end
        chk("rst_test_start", 64'(mdu_start), 64'd1);
        repeat (2) @(negedge clk);
        instr_valid = 0;
        #2;
        rst_n = 0;
        #1;
        check_zero_outputs("async_rst");
`ifdef MDU_FUSE_EN
        orphan = mdl_busy; cv = 0;
`endif
        exp_q.delete();
        @(negedge clk);
        rst_n = 1;
        c = 0;
        while ((mdl_busy || mdu_done) && c < 20) begin
            @(negedge clk);
            c++;
        end
        chk("orphan_drained", 64'(mdl_busy), 64'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] a, b;
        repeat (2) @(negedge clk);
        #1;
        check_zero_outputs("reset");
        @(negedge clk);
        rst_n = 1;
        run_op(FUNCT3_MUL, 7, 6, 5, 0, -1, 2);
        run_op(FUNCT3_MULH, 32'h8000_0000, 1, 6, 0, -1, 3);
        run_op(FUNCT3_MULHU, 32'hFFFF_FFFF, 2, 7, 1, -1, 1);
        run_op(FUNCT3_DIV, 7, 0, 8, 2, -1, 4);
        run_op(FUNCT3_REM, 7, 0, 9, 0, -1, 0);
        run_op(FUNCT3_MUL, 9, 9, 10, 0, 4, 6);
        run_op(FUNCT3_DIVU, 1000, 3, 11, 0, -1, 2);
`ifdef MDU_FUSE_EN
        run_op(FUNCT3_DIV, 100, 7, 12, 0, -1, 3);
        run_op(FUNCT3_REM, 100, 7, 13, 0, -1, 3);
`endif
        reset_mid_wait();
        run_op(FUNCT3_MUL, 3, 7, 14, 0, -1, 2);
        a = 1; b = 1;
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 3) != 0) begin
                a = pick();
                b = pick();
            end
            run_op(3'($urandom_range(0, 7)), a, b, 5'($urandom), $urandom_range(0, 1) ? 0 : $urandom_range(0, 3),
                   $urandom_range(0, 4) == 0 ? $urandom_range(0, 8) : -1, $urandom_range(0, 5));
            idle($urandom_range(0, 2));
        end
        idle(3);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach the end in time");
        $fatal(1, "watchdog expired");
    end
endmodule
